// File: rtl/mem_pkg.sv
// Shared encodings for the instruction-fetch / load-store memory arbiter.
// Owner values double as the requester bit index into the req/gnt vectors.
package mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam int NUM_REQ = 2;

    // Sole requester wins outright; on a conflict the side not served last wins.
    function automatic owner_e rr_pick(input logic [NUM_REQ-1:0] req, input owner_e last);
        if (req == 2'b11) begin
            return (last == OWN_LS) ? OWN_IF : OWN_LS;
        end
        return req[1] ? OWN_LS : OWN_IF;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// last-grant pointer that advances on every accepted request.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic               clock,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt
);

    owner_e last_q;
    owner_e last_d;
    owner_e win;

    assign win = rr_pick(req, last_q);

    always_comb begin
        gnt = '0;
        if (!rst && (req != '0)) begin
            gnt = (win == OWN_LS) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = gnt[1] ? OWN_LS : OWN_IF;
        end
    end

    // Pointer resets to LS so the first conflict goes to instruction fetch.
    always_ff @(posedge clock) begin
        if (rst) begin
            last_q <= OWN_LS;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store:
// accept in cycle N, access in N+1, read data returned with rvalid in N+2.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_rvalid,

    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_rvalid,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_enable,
    output logic                  mem_we,
    output logic                  mem_re
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               accept;

    assign req    = {ls_req, if_req};
    assign accept = |gnt;

    rr_arbiter2 u_rr (
        .clock  (clock),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    assign if_gnt = gnt[0];
    assign ls_gnt = gnt[1];

    state_e                state_q;
    owner_e                owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  re_q;

    // Accepted request is latched here; its memory cycle is the next one.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else if (accept) begin
            state_q <= ACCESS;
            owner_q <= gnt[1] ? OWN_LS : OWN_IF;
            addr_q  <= gnt[1] ? ls_addr : if_addr;
            wdata_q <= ls_wdata;
            we_q    <= gnt[1] & ls_we;
            re_q    <= ~(gnt[1] & ls_we);
        end else begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end
    end

    // rst masks the access combinationally so a mid-access reset never writes.
    logic live;
    assign live       = (state_q == ACCESS) && !rst;
    assign mem_enable = live;
    assign mem_we     = live & we_q;
    assign mem_re     = live & re_q;
    assign mem_addr   = live ? addr_q : '0;
    assign mem_data   = mem_we ? wdata_q : 'z;

    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] ls_rdata_q;
    logic                  if_rvalid_q;
    logic                  ls_rvalid_q;
    logic                  rd_if;
    logic                  rd_ls;

    assign rd_if = mem_re && (owner_q == OWN_IF);
    assign rd_ls = mem_re && (owner_q == OWN_LS);

    always_ff @(posedge clock) begin
        if (rst) begin
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
        end else begin
            if_rvalid_q <= rd_if;
            ls_rvalid_q <= rd_ls;
            if (rd_if) begin
                if_rdata_q <= mem_data;
            end
            if (rd_ls) begin
                ls_rdata_q <= mem_data;
            end
        end
    end

    assign if_rvalid = if_rvalid_q & ~rst;
    assign ls_rvalid = ls_rvalid_q & ~rst;
    assign if_rdata  = rst ? '0 : if_rdata_q;
    assign ls_rdata  = rst ? '0 : ls_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, SHALL exist: ADDR_WIDTH, 10, memory word address width; DATA_WIDTH, 32, memory data width.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch read request; held with if_addr until granted.
REQ-005 if_addr  input  ADDR_WIDTH  fetch word address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rdata  output  DATA_WIDTH  fetch read data.
REQ-008 if_rvalid  output  1  if_rdata valid, one-cycle pulse.
REQ-009 ls_req  input  1  load/store request; held with ls_we/ls_addr/ls_wdata until granted.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_addr  input  ADDR_WIDTH  load/store word address.
REQ-012 ls_wdata  input  DATA_WIDTH  store data.
REQ-013 ls_gnt  output  1  load/store request accepted this cycle.
REQ-014 ls_rdata  output  DATA_WIDTH  load read data.
REQ-015 ls_rvalid  output  1  ls_rdata valid, one-cycle pulse; never pulsed for stores.
REQ-016 mem_addr  output  ADDR_WIDTH  address to shared single-port memory.
REQ-017 mem_data  inout  DATA_WIDTH  shared bidirectional memory data bus.
REQ-018 mem_enable, mem_we, mem_re  output  1 each  memory enable, write enable (sampled on clock edge), read enable (combinational read).

Function
REQ-019 A request SHALL be accepted in the cycle where req and gnt are both high; gnt SHALL be combinational from req and arbitration state, at most one gnt per cycle.
REQ-020 FSM states SHALL be IDLE and ACCESS; IDLE->ACCESS on acceptance; ACCESS->ACCESS on acceptance; ACCESS->IDLE with no acceptance.
REQ-021 Acceptance SHALL be allowed in IDLE and ACCESS, giving one access per cycle sustained throughput.
REQ-022 On acceptance, addr, we, wdata and owner (IF/LS) SHALL be registered; the access SHALL occur in the next cycle (ACCESS).
REQ-023 In ACCESS: mem_enable=1, mem_addr=registered addr; store: mem_we=1, mem_re=0, mem_data driven with wdata; read: mem_re=1, mem_we=0, mem_data high-Z.
REQ-024 Outside ACCESS: mem_enable=mem_we=mem_re=0, mem_data high-Z, mem_addr=0.
REQ-025 mem_we and mem_re SHALL never be high together; the arbiter SHALL never drive mem_data while mem_re=1.
REQ-026 Read data SHALL be sampled from mem_data at the end of ACCESS into the owner's rdata register; owner's rvalid SHALL pulse the following cycle; latency accept->rvalid = 2 cycles.
REQ-027 rdata registers SHALL hold their last value until the next read for that owner.
REQ-028 Only one requester: that requester SHALL be granted immediately.
REQ-029 Both requesting: round-robin; grant the one not granted last; a last-grant pointer SHALL update on every acceptance.
REQ-030 Consequently a held request SHALL be granted within 2 acceptance slots.
REQ-031 Read-after-store to same address from LS SHALL return the stored value (store completes before the next access cycle).

Reset
REQ-032 While rst=1: state=IDLE, if_gnt=ls_gnt=0, no acceptance, in-flight access discarded, if_rvalid=ls_rvalid=0, if_rdata=ls_rdata=0, last-grant pointer=LS (IF wins first conflict), memory controls 0, mem_data high-Z.
REQ-033 rst asserted mid-ACCESS SHALL suppress the pending rvalid and the pending write enable in the following cycle.

Structure
REQ-034 State encoding (IDLE, ACCESS) and owner encoding (OWN_IF=0, OWN_LS=1) SHALL live in a shared package mem_pkg.
REQ-035 Two-way round-robin arbitration SHALL be a sub-module rr_arbiter2 (req[1:0], accept, gnt[1:0], pointer register).

Verification
REQ-036 IF alone, if_addr=0x004, mem[4]=0x12345678 -> if_gnt same cycle, if_rvalid 2 cycles later, if_rdata=0x12345678.
REQ-037 LS store addr 0x010 data 0xDEADBEEF, then LS load 0x010 back-to-back -> one mem_we cycle, load returns 0xDEADBEEF, ls_rvalid once.
REQ-038 IF and LS held high for 6 cycles after reset -> grants alternate IF, LS, IF, LS, IF, LS; mem_enable high 6 consecutive cycles.
REQ-039 Continuous IF reads 0x000..0x007 -> 8 rvalid pulses in 8 consecutive cycles, data in address order.
REQ-040 rst pulsed in the ACCESS cycle of an LS load -> no ls_rvalid, all outputs at reset values, next request serviced normally.
REQ-041 Bus checker all tests -> mem_we&mem_re never 1; mem_data Z whenever mem_we=0.
